ps2_frame_gen: RTL and testbench

//  Parametrised PS/2 device-side frame transmitter: queues scan-code bytes and serialises each as an 11-bit PS/2 frame.

---
 rtl/ps2_pkg.sv | 17 +
 rtl/ps2_byte_fifo.sv | 48 ++++
 rtl/ps2_frame_gen.sv | 173 +++++++++++++++++
 tb/tb_ps2_frame_gen.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encoding, frame layout and parity helpers for the PS/2 frame generator.
package ps2_pkg;

    typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, GAP} state_t;

    localparam int FRAME_BITS = 11;

    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

    // Queued word is {err_stop, err_parity, data}; frame bit 0 goes out first.
    function automatic logic [FRAME_BITS-1:0] build_frame(input logic [9:0] w);
        return {~w[9], odd_parity(w[7:0]) ^ w[8], w[7:0], 1'b0};
    endfunction

endpackage

// File: rtl/ps2_byte_fifo.sv
// ps2_byte_fifo: synchronous FIFO with registered occupancy; full/empty derive from the level count.
module ps2_byte_fifo
    import ps2_pkg::*;
#(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic              do_wr, do_rd;

    assign full    = level == LW'(DEPTH);
    assign empty   = level == '0;
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(do_wr);
            rd_ptr <= rd_ptr + AW'(do_rd);
            level  <= level + LW'(do_wr) - LW'(do_rd);
        end
    end

endmodule

// File: rtl/ps2_frame_gen.sv
// ps2_frame_gen: device-side PS/2 transmitter; queues bytes and serialises each as an 11-bit frame
// with generated clock, error injection, host-inhibit abort/retry and frame counting.
module ps2_frame_gen
    import ps2_pkg::*;
#(
    parameter int CLK_DIV    = 5000,
    parameter int SETUP_CYC  = 5000,
    parameter int GAP_CYC    = 10000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          SYS_CLK,
    input  logic                          reset,
    input  logic                          wr_en,
    input  logic [7:0]                    wr_data,
    input  logic                          err_parity,
    input  logic                          err_stop,
    input  logic                          enable,
    input  logic                          host_inhibit,
    input  logic                          ovf_clr,
    output logic                          ps2_clk_o,
    output logic                          ps2_data_o,
    output logic                          wr_ready,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   frames_sent,
    output logic                          overflow
);

    localparam int MAXP = (CLK_DIV > SETUP_CYC) ? ((CLK_DIV > GAP_CYC) ? CLK_DIV : GAP_CYC)
                                                : ((SETUP_CYC > GAP_CYC) ? SETUP_CYC : GAP_CYC);
    localparam int CW   = $clog2(MAXP) + 1;

    state_t                state, state_n;
    logic [CW-1:0]         cnt, cnt_n;
    logic [3:0]            idx, idx_n, idx_p1;
    logic [FRAME_BITS-1:0] frame, frame_n;
    logic [9:0]            word, word_n, retry_word, rw_n, src, fifo_rd;
    logic                  retry_valid, rv_n, clk_n, data_n;
    logic                  pop, full, empty, inh_m, inh_s, start, abort;
    logic [15:0]           fs_n;

    ps2_byte_fifo #(
        .DATA_W (10),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (SYS_CLK),
        .rst_n   (reset),
        .wr_en   (wr_en),
        .wr_data ({err_stop, err_parity, wr_data}),
        .rd_en   (pop),
        .rd_data (fifo_rd),
        .full    (full),
        .empty   (empty),
        .level   (fifo_level)
    );

    assign wr_ready = !full;
    assign busy     = state != IDLE;
    assign idx_p1   = idx + 4'd1;
    assign src      = retry_valid ? retry_word : fifo_rd;
    assign start    = enable && (retry_valid || !empty) && !inh_s;
    // Once the stop bit's falling edge has gone out the frame is delivered, so inhibit no longer aborts it.
    assign abort    = inh_s && (state == SETUP || ((state == LOW || state == HIGH) && idx != 4'd10));

    always_ff @(posedge SYS_CLK or negedge reset) begin
        if (!reset) begin
            inh_m    <= 1'b0;
            inh_s    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            inh_m    <= host_inhibit;
            inh_s    <= inh_m;
            overflow <= ovf_clr ? 1'b0 : (overflow || (wr_en && full));
        end
    end

    always_ff @(posedge SYS_CLK or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            frame       <= '1;
            word        <= '0;
            retry_word  <= '0;
            retry_valid <= 1'b0;
            ps2_clk_o   <= 1'b1;
            ps2_data_o  <= 1'b1;
            frames_sent <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            frame       <= frame_n;
            word        <= word_n;
            retry_word  <= rw_n;
            retry_valid <= rv_n;
            ps2_clk_o   <= clk_n;
            ps2_data_o  <= data_n;
            frames_sent <= fs_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = idx;
        frame_n = frame;
        word_n  = word;
        rw_n    = retry_word;
        rv_n    = retry_valid;
        clk_n   = ps2_clk_o;
        data_n  = ps2_data_o;
        fs_n    = frames_sent;
        pop     = 1'b0;
        if (abort) begin
            state_n = GAP;
            cnt_n   = '0;
            clk_n   = 1'b1;
            data_n  = 1'b1;
            rv_n    = 1'b1;
            rw_n    = word;
        end else begin
            case (state)
                IDLE: begin
                    cnt_n = '0;
                    if (start) begin
                        state_n = SETUP;
                        word_n  = src;
                        frame_n = build_frame(src);
                        data_n  = 1'b0;
                        pop     = !retry_valid;
                        rv_n    = 1'b0;
                    end
                end
                SETUP: begin
                    if (cnt == CW'(SETUP_CYC - 1)) begin
                        state_n = LOW;
                        cnt_n   = '0;
                        idx_n   = '0;
                        clk_n   = 1'b0;
                    end
                end
                LOW: begin
                    if (cnt == CW'(CLK_DIV - 1)) begin
                        state_n = HIGH;
                        cnt_n   = '0;
                        clk_n   = 1'b1;
                        data_n  = (idx == 4'd10) ? 1'b1 : frame[idx_p1];
                    end
                end
                HIGH: begin
                    if (cnt == CW'(CLK_DIV - 1)) begin
                        cnt_n   = '0;
                        state_n = (idx == 4'd10) ? GAP : LOW;
                        fs_n    = (idx == 4'd10) ? frames_sent + 16'd1 : frames_sent;
                        idx_n   = (idx == 4'd10) ? idx : idx_p1;
                        clk_n   = idx == 4'd10;
                    end
                end
                GAP: begin
                    // After an abort the idle gap only starts counting once the host releases the clock.
                    if (retry_valid && inh_s) cnt_n = '0;
                    else if (cnt == CW'(GAP_CYC - 1)) begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_frame_gen.sv
// tb_ps2_frame_gen: directed scoreboard bench; expected frames are queued at write time and
// compared against the bits captured on each ps2_clk falling edge.
module tb_ps2_frame_gen;

    localparam int CLK_DIV   = 4;
    localparam int SETUP_CYC = 4;
    localparam int GAP_CYC   = 8;
    localparam int DEPTH     = 8;
    localparam int FRAME_LEN = SETUP_CYC + 22 * CLK_DIV + GAP_CYC;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr_en = 1'b0, err_parity = 1'b0, err_stop = 1'b0;
    logic [7:0]  wr_data = '0;
    logic        enable = 1'b1, host_inhibit = 1'b0, ovf_clr = 1'b0;
    logic        ps2_clk_o, ps2_data_o, wr_ready, busy, overflow;
    logic [3:0]  fifo_level;
    logic [15:0] frames_sent;

    int checks = 0;
    int errors = 0;
    int nbits = 0;
    int nfalls = 0;
    int hc = 0;
    int idle_run = 0;
    logic prev_clk = 1'b1, prev_data = 1'b1;
    logic [10:0] cap = '0;
    logic [10:0] exp_q[$];

    ps2_frame_gen #(
        .CLK_DIV    (CLK_DIV),
        .SETUP_CYC  (SETUP_CYC),
        .GAP_CYC    (GAP_CYC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .SYS_CLK      (clk),
        .reset        (rst_n),
        .wr_en        (wr_en),
        .wr_data      (wr_data),
        .err_parity   (err_parity),
        .err_stop     (err_stop),
        .enable       (enable),
        .host_inhibit (host_inhibit),
        .ovf_clr      (ovf_clr),
        .ps2_clk_o    (ps2_clk_o),
        .ps2_data_o   (ps2_data_o),
        .wr_ready     (wr_ready),
        .busy         (busy),
        .fifo_level   (fifo_level),
        .frames_sent  (frames_sent),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] model(input logic [7:0] d, input logic ep, input logic es);
        int ones = 0;
        logic p;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        p = ((ones % 2) == 0) ^ ep;
        return {~es, p, d, 1'b0};
    endfunction

    task automatic wr(input logic [7:0] d, input logic ep, input logic es, input bit pushed);
        wr_en = 1'b1;
        wr_data = d;
        err_parity = ep;
        err_stop = es;
        if (pushed) exp_q.push_back(model(d, ep, es));
        @(negedge clk);
        wr_en = 1'b0;
        err_parity = 1'b0;
        err_stop = 1'b0;
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n = 0;
        while (int'(frames_sent) != target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("frames_sent", 32'(frames_sent), target);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while (busy && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("idle", 32'(busy), 0);
    endtask

    task automatic wait_bits(input int k, input int budget);
        int n = 0;
        while (nbits != k && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("reach_bit", nbits, k);
    endtask

    // Line monitor: captures data at each ps2_clk fall and checks the idle gap before each frame start.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            nbits = 0;
            hc = 0;
        end else begin
            if (prev_data && !ps2_data_o && ps2_clk_o && nbits == 0)
                chk("idle_gap_ok", 32'(idle_run >= GAP_CYC), 1);
            if (prev_clk && !ps2_clk_o) begin
                cap[nbits] = ps2_data_o;
                nbits++;
                nfalls++;
                if (nbits == 11) begin
                    chk("frame_expected", 32'(exp_q.size() != 0), 1);
                    if (exp_q.size() != 0) chk("frame_bits", 32'(cap), 32'(exp_q.pop_front()));
                    nbits = 0;
                end
            end
            hc = ps2_clk_o ? hc + 1 : 0;
            if (hc > CLK_DIV) nbits = 0;
        end
        idle_run = (ps2_clk_o && ps2_data_o) ? idle_run + 1 : 0;
        prev_clk = ps2_clk_o;
        prev_data = ps2_data_o;
    end

    initial begin
        int n;
        int fs0;
        int f0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_clk", 32'(ps2_clk_o), 1);
        chk("rst_data", 32'(ps2_data_o), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_wr_ready", 32'(wr_ready), 1);
        chk("rst_level", 32'(fifo_level), 0);
        chk("rst_frames", 32'(frames_sent), 0);
        chk("rst_overflow", 32'(overflow), 0);
        repeat (10) @(negedge clk);

        wr(8'h1C, 1'b0, 1'b0, 1'b1);
        n = 0;
        while (!busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("busy_rise", 32'(busy), 1);
        n = 0;
        while (busy && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("busy_cycles", n, FRAME_LEN);
        chk("frames_after_1", 32'(frames_sent), 1);

        wr(8'h12, 1'b0, 1'b0, 1'b1);
        wr(8'h33, 1'b0, 1'b0, 1'b1);
        wait_frames(3, 3 * FRAME_LEN);
        wait_idle(50);

        wr(8'h1C, 1'b1, 1'b0, 1'b1);
        wr(8'h1C, 1'b0, 1'b1, 1'b1);
        wait_frames(5, 3 * FRAME_LEN);
        wait_idle(50);

        enable = 1'b0;
        for (int i = 0; i < 8; i++) wr(8'(8'h40 + i), 1'b0, 1'b0, 1'b1);
        chk("full_level", 32'(fifo_level), DEPTH);
        chk("full_wr_ready", 32'(wr_ready), 0);
        chk("ovf_before", 32'(overflow), 0);
        wr(8'hEE, 1'b0, 1'b0, 1'b0);
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_level", 32'(fifo_level), DEPTH);
        repeat (3) @(negedge clk);
        chk("ovf_sticky", 32'(overflow), 1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 0);
        chk("no_start_disabled", 32'(busy), 0);
        enable = 1'b1;
        wait_frames(13, 10 * FRAME_LEN);
        wait_idle(50);
        chk("sb_drained_burst", exp_q.size(), 0);

        fs0 = int'(frames_sent);
        wr(8'h5A, 1'b0, 1'b0, 1'b1);
        wait_bits(5, 2 * FRAME_LEN);
        host_inhibit = 1'b1;
        repeat (3) @(negedge clk);
        chk("inh_clk_high", 32'(ps2_clk_o), 1);
        chk("inh_data_high", 32'(ps2_data_o), 1);
        repeat (20) @(negedge clk);
        chk("inh_held_clk", 32'(ps2_clk_o), 1);
        chk("inh_no_count", 32'(frames_sent), 32'(fs0));
        host_inhibit = 1'b0;
        wait_frames(fs0 + 1, 3 * FRAME_LEN);
        wait_idle(50);
        repeat (30) @(negedge clk);
        chk("retry_once", 32'(frames_sent), 32'(fs0 + 1));
        chk("sb_drained_retry", exp_q.size(), 0);

        wr(8'h77, 1'b0, 1'b0, 1'b1);
        wr(8'h21, 1'b0, 1'b0, 1'b1);
        wait_bits(7, 2 * FRAME_LEN);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_clk", 32'(ps2_clk_o), 1);
        chk("mid_rst_data", 32'(ps2_data_o), 1);
        chk("mid_rst_level", 32'(fifo_level), 0);
        chk("mid_rst_frames", 32'(frames_sent), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        f0 = nfalls;
        repeat (200) @(negedge clk);
        chk("no_edges_after_rst", nfalls, f0);
        chk("frames_after_rst", 32'(frames_sent), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
